// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : mips_pkg
//  Description: Shared constants and types for the MIPS write-back slice.
//               This file holds the load-type codes, the zero-register
//               address and the MEM/WB pipeline-register layout.
//  Revision   : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int WORD_W = 32;

  // These load-type codes are plain constants rather than an enum. The
  // 3-bit field can carry codes that are not defined here, and those codes
  // must decode as WORD.
  localparam logic [2:0] LT_WORD  = 3'd0;
  localparam logic [2:0] LT_BYTE  = 3'd1;
  localparam logic [2:0] LT_BYTEU = 3'd2;
  localparam logic [2:0] LT_HALF  = 3'd3;
  localparam logic [2:0] LT_HALFU = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [2:0]        load_type;
    logic [4:0]        rd;
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] rdata;
  } memwb_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module     : load_align
//  Description: Big-endian load-data alignment. This block is purely
//               combinational. Byte offset 0 maps to bits [31:24].
//  Ports      : rdata     in  32  raw data-memory word
//               offset    in  2   effective-address low bits
//               load_type in  3   LT_* code
//               aligned   out 32  extended, aligned load result
//  Revision   : 1.0 - initial release
// ============================================================================
module load_align
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        load_type,
  output logic [WORD_W-1:0] aligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (offset)
      2'd0:    byte_lane = rdata[31:24];
      2'd1:    byte_lane = rdata[23:16];
      2'd2:    byte_lane = rdata[15:8];
      default: byte_lane = rdata[7:0];
    endcase
    // Halfword accesses use only offset[1]. Offset[0] has no effect on them.
    half_lane = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    aligned = rdata;
    case (load_type)
      LT_BYTE:  aligned = {{24{byte_lane[7]}}, byte_lane};
      LT_BYTEU: aligned = {24'h000000, byte_lane};
      LT_HALF:  aligned = {{16{half_lane[15]}}, half_lane};
      LT_HALFU: aligned = {16'h0000, half_lane};
      default:  aligned = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module     : writeback_stage
//  Description: MIPS WB stage. It contains the MEM/WB pipeline register,
//               the load alignment and the write-back mux. It also holds a
//               retired-instruction counter and an optional ID-stage bypass.
//               When no write is due, the register-file port is parked on
//               address 0 with data 0, so r0 stays at zero.
//  Config     : WB_BYPASS_EN - when defined, ID operands are forwarded from
//               the write in flight. When undefined, they pass straight
//               through from the register file.
//  Ports      : i_clk/i_reset         clock, asynchronous active-high reset
//               i_stall/i_flush       hold / invalidate the MEM/WB entry
//               i_mem_*               MEM-stage instruction fields
//               i_id_rs/rt, i_rf_src* ID-stage source addresses and RF data
//               o_wb_data/addr/en     register-file write port
//               o_id_src1/2           ID operands (optionally bypassed)
//               o_retired             retired-instruction count
//  Revision   : 1.0 - initial release
// ============================================================================
module writeback_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_mem_valid,
  input  logic              i_mem_reg_write,
  input  logic              i_mem_to_reg,
  input  logic [2:0]        i_mem_load_type,
  input  logic [4:0]        i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_alu_result,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [4:0]        i_id_rs,
  input  logic [4:0]        i_id_rt,
  input  logic [DATA_W-1:0] i_rf_src1,
  input  logic [DATA_W-1:0] i_rf_src2,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [4:0]        o_wb_addr,
  output logic              o_wb_en,
  output logic [DATA_W-1:0] o_id_src1,
  output logic [DATA_W-1:0] o_id_src2,
  output logic [CNT_W-1:0]  o_retired
);

  memwb_t            entry;
  logic [CNT_W-1:0]  retired;
  logic [DATA_W-1:0] aligned;
  logic              wb_en;

  // Flush has priority over stall. A stalled entry keeps every field, so the
  // same write is driven again each cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      entry   <= '0;
      retired <= '0;
    end else begin
      if (i_flush) begin
        entry.valid <= 1'b0;
      end else if (!i_stall) begin
        entry.valid      <= i_mem_valid;
        entry.reg_write  <= i_mem_reg_write;
        entry.mem_to_reg <= i_mem_to_reg;
        entry.load_type  <= i_mem_load_type;
        entry.rd         <= i_mem_rd;
        entry.alu_result <= i_mem_alu_result;
        entry.rdata      <= i_mem_rdata;
      end
      if (i_mem_valid && !i_stall && !i_flush) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  load_align u_load_align (
    .rdata     (entry.rdata),
    .offset    (entry.alu_result[1:0]),
    .load_type (entry.load_type),
    .aligned   (aligned)
  );

  assign wb_en     = entry.valid & entry.reg_write & (entry.rd != REG_ZERO);
  assign o_wb_en   = wb_en;
  assign o_wb_addr = wb_en ? entry.rd : REG_ZERO;
  assign o_wb_data = !wb_en          ? '0 :
                     entry.mem_to_reg ? aligned : entry.alu_result;
  assign o_retired = retired;

`ifdef WB_BYPASS_EN
  // The register file writes and reads in the same cycle. This forwards the
  // write in flight to the ID stage. When the port is parked (wb_en=0),
  // nothing is forwarded.
  assign o_id_src1 = (wb_en && (i_id_rs == o_wb_addr)) ? o_wb_data : i_rf_src1;
  assign o_id_src2 = (wb_en && (i_id_rt == o_wb_addr)) ? o_wb_data : i_rf_src2;
`else
  assign o_id_src1 = i_rf_src1;
  assign o_id_src2 = i_rf_src2;
  // The address ports stay present without bypass but are not used.
  logic unused_id_addr;
  assign unused_id_addr = ^{i_id_rs, i_id_rt};
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module     : tb_writeback_stage
//  Description: Directed, self-checking bench for writeback_stage.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        mem_valid, mem_reg_write, mem_to_reg;
  logic [2:0]  mem_load_type;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result, mem_rdata;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] rf_src1, rf_src2;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en;
  logic [31:0] id_src1, id_src2;
  logic [31:0] retired;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_W(32), .CNT_W(32)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_mem_valid      (mem_valid),
    .i_mem_reg_write  (mem_reg_write),
    .i_mem_to_reg     (mem_to_reg),
    .i_mem_load_type  (mem_load_type),
    .i_mem_rd         (mem_rd),
    .i_mem_alu_result (mem_alu_result),
    .i_mem_rdata      (mem_rdata),
    .i_id_rs          (id_rs),
    .i_id_rt          (id_rt),
    .i_rf_src1        (rf_src1),
    .i_rf_src2        (rf_src2),
    .o_wb_data        (wb_data),
    .o_wb_addr        (wb_addr),
    .o_wb_en          (wb_en),
    .o_id_src1        (id_src1),
    .o_id_src2        (id_src2),
    .o_retired        (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_in(input logic v, input logic rw, input logic m2r,
                        input logic [2:0] lt, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rdat);
    mem_valid = v; mem_reg_write = rw; mem_to_reg = m2r;
    mem_load_type = lt; mem_rd = rd; mem_alu_result = alu; mem_rdata = rdat;
  endtask

  task automatic check_port(input string tag, input logic en, input logic [4:0] addr,
                            input logic [31:0] data, input logic [31:0] ret);
    check({tag, "_en"},   {31'd0, wb_en}, {31'd0, en});
    check({tag, "_addr"}, {27'd0, wb_addr}, {27'd0, addr});
    check({tag, "_data"}, wb_data, data);
    check({tag, "_ret"},  retired, ret);
  endtask

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t lv [5];
  logic [31:0] bypass_exp;

  initial begin
    lv[0] = '{3'd1, 2'd0, 32'hFFFF_FF80};  // BYTE off0
    lv[1] = '{3'd1, 2'd3, 32'h0000_0001};  // BYTE off3
    lv[2] = '{3'd4, 2'd2, 32'h0000_7F01};  // HALFU off2
    lv[3] = '{3'd3, 2'd0, 32'hFFFF_80FF};  // HALF off0
    lv[4] = '{3'd7, 2'd1, 32'h80FF_7F01};  // undefined code acts as WORD

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_in(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    id_rs = 5'd0; id_rt = 5'd0; rf_src1 = 32'd0; rf_src2 = 32'd0;
    step(); step();
    rst = 1'b0;
    step();
    check_port("reset", 1'b0, 5'd0, 32'd0, 32'd0);

    // ALU write
    mem_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
    step();
    check_port("alu", 1'b1, 5'd5, 32'h1234_5678, 32'd1);

    // Load alignment
    for (int i = 0; i < 5; i++) begin
      mem_in(1'b1, 1'b1, 1'b1, lv[i].lt, 5'd7, {30'h1000_0000, lv[i].off}, 32'h80FF_7F01);
      step();
      check($sformatf("load%0d", i), wb_data, lv[i].exp);
    end
    check("load_ret", retired, 32'd6);

    // Writes that must not reach the register file still retire.
    mem_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 32'h5555_AAAA, 32'd0);
    step();
    check_port("rd0", 1'b0, 5'd0, 32'd0, 32'd7);
    mem_in(1'b1, 1'b0, 1'b0, 3'd0, 5'd3, 32'h5555_AAAA, 32'd0);
    step();
    check_port("norw", 1'b0, 5'd0, 32'd0, 32'd8);

    // Stall holds the entry while a new input is pending.
    mem_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd4, 32'hCAFE_F00D, 32'd0);
    step();
    check_port("pre_stall", 1'b1, 5'd4, 32'hCAFE_F00D, 32'd9);
    mem_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd6, 32'h1111_1111, 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_port($sformatf("stall%0d", i), 1'b1, 5'd4, 32'hCAFE_F00D, 32'd9);
    end
    flush = 1'b1;
    step();
    check_port("stall_flush", 1'b0, 5'd0, 32'd0, 32'd9);
    stall = 1'b0; flush = 1'b0;
    step();
    check_port("resume", 1'b1, 5'd6, 32'h1111_1111, 32'd10);
    flush = 1'b1;
    step();
    check_port("flush", 1'b0, 5'd0, 32'd0, 32'd10);
    flush = 1'b0;

    // Bypass toward the ID stage.
    mem_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd9, 32'hA5A5_A5A5, 32'd0);
    step();
    id_rs = 5'd9; rf_src1 = 32'd0; id_rt = 5'd9; rf_src2 = 32'h1357_9BDF;
    #1;
`ifdef WB_BYPASS_EN
    bypass_exp = 32'hA5A5_A5A5;
    check("byp_src2", id_src2, 32'hA5A5_A5A5);
`else
    bypass_exp = 32'd0;
    check("byp_src2", id_src2, 32'h1357_9BDF);
`endif
    check("byp_src1", id_src1, bypass_exp);
    id_rs = 5'd0; id_rt = 5'd3;
    #1;
    check("byp_rs0", id_src1, 32'd0);
    check("byp_rt3", id_src2, 32'h1357_9BDF);

    // Apply an asynchronous reset in mid-cycle while a stall is active.
    mem_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd12, 32'h0BAD_CAFE, 32'd0);
    step();
    check_port("pre_rst", 1'b1, 5'd12, 32'h0BAD_CAFE, 32'd12);
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_port("async_rst", 1'b0, 5'd0, 32'd0, 32'd0);
    step();
    rst = 1'b0; stall = 1'b0;
    mem_in(1'b0, 1'b1, 1'b0, 3'd0, 5'd12, 32'h0BAD_CAFE, 32'd0);
    step();
    check_port("post_rst", 1'b0, 5'd0, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
